// File: rtl/apb_mux_pkg.sv
// apb_mux_pkg: shared types and the priority decoder for the APB decode/response mux
package apb_mux_pkg;
    localparam int MAX_SLAVES = 256;
    localparam int PDATA_MAX  = 32;
    typedef enum logic [1:0] {IDLE, ACCESS, UNMAPPED, ABORT} state_t;
    typedef struct packed {
        logic [PDATA_MAX-1:0] prdata;
        logic                 pready;
        logic                 pslverr;
    } apb_rsp_t;
    typedef struct packed {
        logic       found;
        logic [7:0] idx;
    } dec_t;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    function automatic dec_t lowest_hit(input logic [MAX_SLAVES-1:0] hit);
        dec_t d;
        d = '{found: 1'b0, idx: 8'd0};
        for (int i = MAX_SLAVES - 1; i >= 0; i--)
            if (hit[i]) d = '{found: 1'b1, idx: 8'(i)};
        return d;
    endfunction
endpackage

// File: rtl/apb_wdt_counter.sv
// apb_wdt_counter: saturating access-phase cycle counter that flags expiry at TMO_CYCLES-1
module apb_wdt_counter #(
    parameter int TMO_CYCLES = 255
)(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expire
);
    localparam int CW = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? '0 : (en && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
    assign expire = (TMO_CYCLES != 0) && (cnt_q == CW'(TMO_CYCLES - 1));
endmodule

// File: rtl/apb_decode_mux_wdt.sv
// apb_decode_mux_wdt: APB address decoder/response mux with access watchdog, unmapped error and error counter
module apb_decode_mux_wdt
    import apb_mux_pkg::*;
#(
    parameter int PADDR_SIZE = 16,
    parameter int PDATA_SIZE = 8,
    parameter int SLAVES     = 8,
    parameter int TMO_CYCLES = 255,
    parameter int ERRCNT_W   = 8
)(
    input  logic                                 PCLK,
    input  logic                                 PRESET,
    input  logic                                 MST_PSEL,
    input  logic                                 MST_PENABLE,
    input  logic [PADDR_SIZE-1:0]                MST_PADDR,
    output logic [PDATA_SIZE-1:0]                MST_PRDATA,
    output logic                                 MST_PREADY,
    output logic                                 MST_PSLVERR,
    input  logic [SLAVES-1:0][PADDR_SIZE-1:0]    slv_addr,
    input  logic [SLAVES-1:0][PADDR_SIZE-1:0]    slv_mask,
    output logic [SLAVES-1:0]                    SLV_PSEL,
    input  logic [SLAVES-1:0][PDATA_SIZE-1:0]    SLV_PRDATA,
    input  logic [SLAVES-1:0]                    SLV_PREADY,
    input  logic [SLAVES-1:0]                    SLV_PSLVERR,
    output logic                                 tmo_o,
    output logic [idx_w(SLAVES)-1:0]             tmo_idx_o,
    output logic [ERRCNT_W-1:0]                  err_cnt_o,
    input  logic                                 err_clr_i
);
    localparam int IW = idx_w(SLAVES);
    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d, tmo_idx_q, tmo_idx_d;
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [SLAVES-1:0] hit;
    dec_t              dec;
    apb_rsp_t          rsp;
    logic              setup, wdt_en, wdt_clr, wdt_exp, err_inc;
    assign setup = MST_PSEL & ~MST_PENABLE;
    always_comb begin
        for (int i = 0; i < SLAVES; i++)
            hit[i] = ((MST_PADDR ^ slv_addr[i]) & slv_mask[i]) == '0;
        dec = lowest_hit(MAX_SLAVES'(hit));
    end
    apb_wdt_counter #(.TMO_CYCLES(TMO_CYCLES)) u_wdt (
        .clk    (PCLK),
        .rst    (PRESET),
        .en     (wdt_en),
        .clr    (wdt_clr),
        .expire (wdt_exp)
    );
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        SLV_PSEL = '0;
        rsp      = '0;
        wdt_en   = 1'b0;
        case (state_q)
            ACCESS: begin
                SLV_PSEL[idx_q] = 1'b1;
                rsp = '{prdata: PDATA_MAX'(SLV_PRDATA[idx_q]), pready: SLV_PREADY[idx_q],
                        pslverr: SLV_PSLVERR[idx_q]};
                if (!MST_PSEL || (MST_PENABLE && SLV_PREADY[idx_q]))
                    state_d = IDLE;
                else if (MST_PENABLE) begin
                    wdt_en = 1'b1;
                    if (wdt_exp) state_d = ABORT;
                end
            end
            UNMAPPED: begin
                rsp.pready  = MST_PENABLE;
                rsp.pslverr = MST_PENABLE;
                if (MST_PENABLE || !MST_PSEL) state_d = IDLE;
            end
            ABORT: begin
                rsp.pready  = 1'b1;
                rsp.pslverr = 1'b1;
                state_d     = IDLE;
            end
            default: ;
        endcase
        // a setup phase re-decodes and selects the winner in the same cycle
        if (setup && (state_q == IDLE || state_q == ACCESS)) begin
            SLV_PSEL = '0;
            SLV_PSEL[IW'(dec.idx)] = dec.found;
            idx_d   = IW'(dec.idx);
            state_d = dec.found ? ACCESS : UNMAPPED;
        end
    end
    assign wdt_clr     = setup | (state_q == IDLE);
    assign MST_PREADY  = rsp.pready & ~PRESET;
    assign MST_PSLVERR = rsp.pslverr;
    assign MST_PRDATA  = rsp.prdata[PDATA_SIZE-1:0];
    assign tmo_o       = state_q == ABORT;
    assign tmo_idx_o   = tmo_idx_q;
    assign err_cnt_o   = err_cnt_q;
    assign err_inc     = MST_PSEL & MST_PENABLE & MST_PREADY & MST_PSLVERR;
    always_comb begin
        tmo_idx_d = (state_q == ABORT) ? idx_q : tmo_idx_q;
        err_cnt_d = err_clr_i ? '0 : (err_inc && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;
    end
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            tmo_idx_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tmo_idx_q <= tmo_idx_d;
            err_cnt_q <= err_cnt_d;
        end
    end
endmodule

// File: tb/tb_apb_decode_mux_wdt.sv
// tb_apb_decode_mux_wdt: randomized self-checking bench against an address-window reference model
module tb_apb_decode_mux_wdt;
    localparam int AW = 16, DW = 8, NS = 8, TMO = 4, EW = 8;
    logic PCLK = 1'b0;
    logic PRESET, MST_PSEL, MST_PENABLE, err_clr_i;
    logic [AW-1:0] MST_PADDR;
    logic [DW-1:0] MST_PRDATA;
    logic MST_PREADY, MST_PSLVERR, tmo_o;
    logic [NS-1:0][AW-1:0] slv_addr, slv_mask;
    logic [NS-1:0] SLV_PSEL, SLV_PREADY, SLV_PSLVERR;
    logic [NS-1:0][DW-1:0] SLV_PRDATA;
    logic [2:0] tmo_idx_o;
    logic [EW-1:0] err_cnt_o;
    int checks = 0, failures = 0;
    int m_err = 0, m_tmo_idx = 0;
    int base [NS] = '{32'h0000, 32'h0000, 32'h0200, 32'h0130, 32'h0400, 32'h0500, 32'h1000, 32'h2000};
    int size [NS] = '{32'h0100, 32'h0010, 32'h0100, 32'h0010, 32'h0100, 32'h0100, 32'h1000, 32'h1000};

    apb_decode_mux_wdt #(.PADDR_SIZE(AW), .PDATA_SIZE(DW), .SLAVES(NS), .TMO_CYCLES(TMO), .ERRCNT_W(EW)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .MST_PSEL(MST_PSEL), .MST_PENABLE(MST_PENABLE), .MST_PADDR(MST_PADDR),
        .MST_PRDATA(MST_PRDATA), .MST_PREADY(MST_PREADY), .MST_PSLVERR(MST_PSLVERR),
        .slv_addr(slv_addr), .slv_mask(slv_mask), .SLV_PSEL(SLV_PSEL), .SLV_PRDATA(SLV_PRDATA),
        .SLV_PREADY(SLV_PREADY), .SLV_PSLVERR(SLV_PSLVERR), .tmo_o(tmo_o), .tmo_idx_o(tmo_idx_o),
        .err_cnt_o(err_cnt_o), .err_clr_i(err_clr_i)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_target(input int addr);
        for (int i = 0; i < NS; i++)
            if (addr >= base[i] && addr < base[i] + size[i]) return i;
        return -1;
    endfunction

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic scramble();
        for (int i = 0; i < NS; i++) SLV_PRDATA[i] = DW'($urandom);
        SLV_PREADY  = NS'($urandom);
        SLV_PSLVERR = NS'($urandom);
    endtask

    task automatic idle(input int n);
        MST_PSEL = 1'b0;
        MST_PENABLE = 1'b0;
        err_clr_i = 1'b0;
        repeat (n) tick();
    endtask

    task automatic xfer(input logic [AW-1:0] addr, input int waits, input logic err, input logic clr);
        int t = ref_target(int'(addr));
        logic [DW-1:0] d = DW'($urandom);
        logic [NS-1:0] sel = (t < 0) ? '0 : NS'(1) << t;
        bit done = 1'b0;
        bit e;
        MST_PSEL = 1'b1; MST_PENABLE = 1'b0; MST_PADDR = addr; err_clr_i = 1'b0;
        scramble();
        @(negedge PCLK);
        chk("setup_psel", 32'(SLV_PSEL), 32'(sel));
        chk("setup_pready", 32'(MST_PREADY), 0);
        chk("err_cnt", 32'(err_cnt_o), m_err);
        chk("tmo_idx", 32'(tmo_idx_o), m_tmo_idx);
        chk("tmo_o_quiet", 32'(tmo_o), 0);
        tick();
        MST_PENABLE = 1'b1; err_clr_i = clr;
        for (int k = 0; k <= 16 && !done; k++) begin
            scramble();
            if (t >= 0) begin
                SLV_PREADY[t] = (k >= waits);
                SLV_PRDATA[t] = d;
                SLV_PSLVERR[t] = err;
            end
            @(negedge PCLK);
            if (t < 0 || (k == TMO && waits >= TMO)) begin
                chk("err_prdata", 32'(MST_PRDATA), 0);
                chk("err_pready", 32'(MST_PREADY), 1);
                chk("err_pslverr", 32'(MST_PSLVERR), 1);
                chk("err_psel", 32'(SLV_PSEL), 0);
                chk("tmo_pulse", 32'(tmo_o), (t >= 0) ? 1 : 0);
                if (t >= 0) m_tmo_idx = t;
                e = 1'b1;
                done = 1'b1;
            end else if (k >= waits) begin
                chk("done_prdata", 32'(MST_PRDATA), 32'(d));
                chk("done_pready", 32'(MST_PREADY), 1);
                chk("done_pslverr", 32'(MST_PSLVERR), 32'(err));
                chk("done_psel", 32'(SLV_PSEL), 32'(sel));
                e = err;
                done = 1'b1;
            end else begin
                chk("wait_pready", 32'(MST_PREADY), 0);
                chk("wait_psel", 32'(SLV_PSEL), 32'(sel));
                chk("wait_tmo", 32'(tmo_o), 0);
            end
            if (done) m_err = clr ? 0 : (e && m_err < 255) ? m_err + 1 : m_err;
            tick();
        end
        if (!done) chk("xfer_timeout", 0, 1);
        MST_PSEL = 1'b0; MST_PENABLE = 1'b0; err_clr_i = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NS; i++) begin
            slv_addr[i] = AW'(base[i]);
            slv_mask[i] = AW'(~(size[i] - 1));
        end
        PRESET = 1'b1; MST_PSEL = 1'b0; MST_PENABLE = 1'b0; MST_PADDR = '0; err_clr_i = 1'b0;
        SLV_PRDATA = '0; SLV_PREADY = '0; SLV_PSLVERR = '0;
        tick(); tick();
        @(negedge PCLK);
        chk("rst_psel", 32'(SLV_PSEL), 0);
        chk("rst_pready", 32'(MST_PREADY), 0);
        chk("rst_pslverr", 32'(MST_PSLVERR), 0);
        chk("rst_prdata", 32'(MST_PRDATA), 0);
        chk("rst_tmo", 32'(tmo_o), 0);
        chk("rst_tmo_idx", 32'(tmo_idx_o), 0);
        chk("rst_err_cnt", 32'(err_cnt_o), 0);
        tick();
        PRESET = 1'b0;
        xfer(16'h0130, 0, 1'b0, 1'b0);
        xfer(16'h7000, 0, 1'b0, 1'b0);
        xfer(16'h0250, 10, 1'b0, 1'b0);
        idle(1);
        xfer(16'h0000, 1, 1'b0, 1'b0);
        xfer(16'h0510, 0, 1'b1, 1'b0);
        idle(1);
        MST_PSEL = 1'b1; MST_PENABLE = 1'b0; MST_PADDR = 16'h0420; SLV_PREADY = '0;
        tick();
        MST_PENABLE = 1'b1;
        @(negedge PCLK);
        chk("mabort_access_psel", 32'(SLV_PSEL), 32'h10);
        tick();
        MST_PSEL = 1'b0; MST_PENABLE = 1'b0;
        @(negedge PCLK);
        chk("mabort_hold_psel", 32'(SLV_PSEL), 32'h10);
        tick();
        @(negedge PCLK);
        chk("mabort_drop_psel", 32'(SLV_PSEL), 0);
        chk("mabort_err_cnt", 32'(err_cnt_o), m_err);
        tick();
        MST_PSEL = 1'b1; MST_PENABLE = 1'b0; MST_PADDR = 16'h0210; SLV_PREADY = '0;
        tick();
        MST_PENABLE = 1'b1;
        tick(); tick();
        SLV_PREADY[2] = 1'b1; PRESET = 1'b1;
        @(negedge PCLK);
        chk("rstmid_pready", 32'(MST_PREADY), 0);
        tick();
        PRESET = 1'b0; MST_PSEL = 1'b0; MST_PENABLE = 1'b0; SLV_PREADY = '0;
        m_err = 0; m_tmo_idx = 0;
        @(negedge PCLK);
        chk("rstmid_psel", 32'(SLV_PSEL), 0);
        chk("rstmid_pslverr", 32'(MST_PSLVERR), 0);
        chk("rstmid_prdata", 32'(MST_PRDATA), 0);
        chk("rstmid_tmo", 32'(tmo_o), 0);
        chk("rstmid_tmo_idx", 32'(tmo_idx_o), 0);
        chk("rstmid_err_cnt", 32'(err_cnt_o), 0);
        tick();
        xfer(16'h0138, 1, 1'b0, 1'b0);
        repeat (260) xfer(16'h7000, 0, 1'b0, 1'b0);
        idle(1);
        @(negedge PCLK);
        chk("err_saturate", 32'(err_cnt_o), 255);
        tick();
        xfer(16'h7000, 0, 1'b0, 1'b1);
        idle(1);
        @(negedge PCLK);
        chk("err_clr_wins", 32'(err_cnt_o), 0);
        tick();
        for (int n = 0; n < 300; n++) begin
            int pick = $urandom_range(0, 9);
            logic [AW-1:0] a;
            if (pick < NS) a = AW'(base[pick] + $urandom_range(0, size[pick] - 1));
            else if (pick == NS) a = AW'(32'h3000 + $urandom_range(0, 32'hCFFF));
            else a = AW'(32'h0600 + $urandom_range(0, 32'h09FF));
            xfer(a, $urandom_range(0, 6), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 2) == 0) idle(1);
        end
        idle(1);
        @(negedge PCLK);
        chk("final_err_cnt", 32'(err_cnt_o), m_err);
        chk("final_tmo_idx", 32'(tmo_idx_o), m_tmo_idx);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
